uart_image_loader: RTL and testbench
====================================

# uart_image_loader

Receives a raw image over a UART serial line, unpacks two 3-bit RGB pixels from each byte and drives the frame-memory write port (address, data, write enable) consumed by the sketch/plot stage. It sits between the board's `UART_RXD` pin and the image RAM. It asserts `endOfUartPackets` once a full 160x120 frame has been written, so the top-level state machine can leave the fill state and start plotting.

## Interface

Parameters:
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, serial bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (434 at defaults).
- `NUM_PIXELS`, 19200, pixels per frame; must be even.
- `ADDR_W`, 15, memory address width.

Ports:
- `CLOCK_50`, in, 1, system clock; all logic on its rising edge.
- `resetn`, in, 1, asynchronous active-low reset.
- `UART_RXD`, in, 1, serial input, idle high, asynchronous to the clock.
- `start`, in, 1, one-cycle request to begin loading a frame.
- `mem_addr_write`, out, `ADDR_W`, pixel write address.
- `mem_data_write`, out, 3, pixel colour {R,G,B}.
- `memory_write_en`, out, 1, write strobe, one cycle per pixel.
- `endOfUartPackets`, out, 1, frame complete; level signal.
- `busy`, out, 1, high while in state LOAD.
- `framing_err`, out, 1, sticky error flag; cleared by `start`.

## Operation

Receiver:
- `UART_RXD` passes through a 2-flop synchroniser.
- Start detection: the receiver waits for a falling edge while idle.
- Start-bit check: the line is re-sampled at half-bit (217 cycles). If it reads 1 there, the edge is treated as a glitch and the receiver returns to idle.
- Data: 8 bits, LSB first, each sampled at the middle of its bit (every 434 cycles).
- Stop bit sampled at its midpoint:
  - If it is 1, `rx_valid` pulses for one cycle with `rx_byte`.
  - If it is 0, the byte is discarded, `framing_err` is set, and the receiver waits for the line to go high before re-arming.

Byte packing:
- `byte[2:0]` is the pixel at the even address.
- `byte[5:3]` is the pixel at the next, odd address.
- `byte[7:6]` is ignored.

Loader FSM, states IDLE, LOAD, WRITE_HI, DONE:
- **IDLE**: outputs low, address 0. On `start`, go to LOAD and clear `framing_err`.
- **LOAD**: on `rx_valid`, present `byte[2:0]` at the current address with `memory_write_en`=1, latch `byte[5:3]`, and go to WRITE_HI.
- **WRITE_HI**: present the latched pixel at address+1 with `memory_write_en`=1.
  - If address+1 == `NUM_PIXELS`-1, go to DONE.
  - Otherwise advance the address by 2 and return to LOAD.
- **DONE**: `endOfUartPackets`=1 and address held at 0. On `start`, clear `framing_err`, deassert `endOfUartPackets` and go to LOAD.

Event handling:
- Bytes received in IDLE or DONE are discarded.
- `start` while in LOAD or WRITE_HI is ignored.
- Address arithmetic is unsigned `ADDR_W`-bit. Address never exceeds `NUM_PIXELS`-1 and never wraps.

## Timing

- Reset values:
  - `mem_addr_write`=0, `mem_data_write`=0, `memory_write_en`=0.
  - `endOfUartPackets`=0, `busy`=0, `framing_err`=0.
  - FSM in IDLE, receiver idle.
- Reset mid-frame aborts the load. After release, loading resumes only on a new `start`, from address 0.
- Write timing:
  - Even-pixel write is registered, in the cycle after the `rx_valid` pulse.
  - Odd-pixel write follows in the next cycle.
  - `memory_write_en` is never high for more than 2 consecutive cycles.
- `rx_valid` occurs at the stop-bit midpoint, about 9.5 bit times (≈4123 cycles) after the start edge.
- `endOfUartPackets` rises the cycle after the final odd-pixel write.
- No FIFO is needed: byte spacing (≥4340 cycles) far exceeds the 2-cycle write burst.
- `busy` is registered and high exactly in LOAD/WRITE_HI.

## Configuration

- `LOADER_PARITY_EN` defined:
  - The receiver expects an even-parity bit between data bit 7 and the stop bit (8E1).
  - A parity mismatch is handled exactly like a bad stop bit: byte discarded and `framing_err` set.
- `LOADER_PARITY_EN` undefined: the frame is 8N1 and there is no parity logic.

## Test plan

- **Single byte**: reset, `start`, send 0x2C at 115200 baud.
  - Required: write (addr 0, data 3'b100), then next cycle (addr 1, data 3'b101), then `busy`=1, `endOfUartPackets`=0.
- **Full frame**: with `NUM_PIXELS`=8, send 0x3F, 0x00, 0x12, 0x09.
  - Required: 8 writes at addrs 0–7 with data 7,7,0,0,2,2,1,1, then `endOfUartPackets`=1 one cycle after the addr-7 write.
- **Framing error**: send 0x55 with stop bit forced to 0, then 0x07.
  - Required: `framing_err`=1; exactly 2 writes, at addr 0 (data 7) and addr 1 (data 0).
- **Glitch and idle bytes**: a 100-cycle low pulse on `UART_RXD` yields no `rx_valid`; bytes sent before `start` produce no writes.
- **Reset mid-frame**: assert `resetn`=0 after 3 bytes.
  - Required: all outputs 0 immediately; after `start`, the next byte writes addr 0.
- **Parity** (`LOADER_PARITY_EN`): send 0x03 with odd parity.
  - Required: `framing_err`=1 and no write.

Source files
------------

// File: rtl/uart_image_loader.sv
// UART (8N1, or 8E1 with LOADER_PARITY_EN) receiver feeding a frame-memory writer:
// each byte carries two 3-bit RGB pixels, written to consecutive addresses.
module uart_image_loader #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int NUM_PIXELS = 19200,
  parameter int ADDR_W     = 15
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              UART_RXD,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr_write,
  output logic [2:0]        mem_data_write,
  output logic              memory_write_en,
  output logic              endOfUartPackets,
  output logic              busy,
  output logic              framing_err
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE_HI, DONE} ld_state_t;

  // ---------------- receiver ----------------
  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  rx_state_t     rs, rs_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    sh, sh_n;
  logic          rx_valid, rx_valid_n, rx_err, rx_err_n, par_ok;
  logic          tick, half;

  assign rx_s = sync[1];
  assign tick = (cnt == CW'(CPB - 1));
  assign half = (cnt == CW'(HALF - 1));

`ifdef LOADER_PARITY_EN
  logic par_bad, par_bad_n;
  assign par_ok = ~par_bad;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    rs_n       = rs;
    cnt_n      = cnt + CW'(1);
    bidx_n     = bidx;
    sh_n       = sh;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
`ifdef LOADER_PARITY_EN
    par_bad_n  = par_bad;
`endif
    case (rs)
      R_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) rs_n = R_START;
      end
      R_START: if (half) begin
        cnt_n  = '0;
        bidx_n = '0;
        rs_n   = rx_s ? R_IDLE : R_DATA;  // high at mid start bit: glitch
      end
      R_DATA: if (tick) begin
        cnt_n  = '0;
        sh_n   = {rx_s, sh[7:1]};
        bidx_n = bidx + 3'd1;
`ifdef LOADER_PARITY_EN
        if (bidx == 3'd7) rs_n = R_PAR;
`else
        if (bidx == 3'd7) rs_n = R_STOP;
`endif
      end
`ifdef LOADER_PARITY_EN
      R_PAR: if (tick) begin
        cnt_n     = '0;
        par_bad_n = ^{sh, rx_s};
        rs_n      = R_STOP;
      end
`endif
      R_STOP: if (tick) begin
        cnt_n = '0;
        if (rx_s && par_ok) begin
          rx_valid_n = 1'b1;
          rs_n       = R_IDLE;
        end else begin
          rx_err_n = 1'b1;
          rs_n     = R_WAIT;
        end
      end
      R_WAIT: begin
        cnt_n = '0;
        if (rx_s) rs_n = R_IDLE;
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      rs       <= R_IDLE;
      cnt      <= '0;
      bidx     <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
`ifdef LOADER_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      sync     <= {sync[0], UART_RXD};
      rx_prev  <= rx_s;
      rs       <= rs_n;
      cnt      <= cnt_n;
      bidx     <= bidx_n;
      sh       <= sh_n;
      rx_valid <= rx_valid_n;
      rx_err   <= rx_err_n;
`ifdef LOADER_PARITY_EN
      par_bad  <= par_bad_n;
`endif
    end
  end

  // ---------------- loader ----------------
  ld_state_t         st, st_n;
  logic [ADDR_W-1:0] addr, addr_n, wa_n;
  logic [2:0]        hi_pix, hi_n, wd_n;
  logic              we_n, clr, busy_n, eop_n;

  always_comb begin
    st_n   = st;
    addr_n = addr;
    hi_n   = hi_pix;
    we_n   = 1'b0;
    wa_n   = '0;
    wd_n   = '0;
    clr    = 1'b0;
    case (st)
      IDLE, DONE: begin
        addr_n = '0;
        if (start) begin
          st_n = LOAD;
          clr  = 1'b1;
        end
      end
      LOAD: if (rx_valid) begin
        we_n = 1'b1;
        wa_n = addr;
        wd_n = sh[2:0];
        hi_n = sh[5:3];
        st_n = WRITE_HI;
      end
      WRITE_HI: begin
        we_n = 1'b1;
        wa_n = addr + ADDR_W'(1);
        wd_n = hi_pix;
        if (addr + ADDR_W'(1) == LAST) begin
          st_n   = DONE;
          addr_n = '0;
        end else begin
          st_n   = LOAD;
          addr_n = addr + ADDR_W'(2);
        end
      end
      default: st_n = IDLE;
    endcase
    busy_n = (st_n == LOAD) || (st_n == WRITE_HI);
    // one cycle behind DONE entry, so it rises after the last odd write
    eop_n  = (st == DONE) && !start;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st               <= IDLE;
      addr             <= '0;
      hi_pix           <= '0;
      mem_addr_write   <= '0;
      mem_data_write   <= '0;
      memory_write_en  <= 1'b0;
      busy             <= 1'b0;
      endOfUartPackets <= 1'b0;
      framing_err      <= 1'b0;
    end else begin
      st               <= st_n;
      addr             <= addr_n;
      hi_pix           <= hi_n;
      mem_addr_write   <= wa_n;
      mem_data_write   <= wd_n;
      memory_write_en  <= we_n;
      busy             <= busy_n;
      endOfUartPackets <= eop_n;
      if (clr)    framing_err <= 1'b0;
      if (rx_err) framing_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench for uart_image_loader: stimulus pushes expected pixel writes,
// a negedge monitor pops and compares every memory write.
module tb_uart_image_loader;
  localparam int NP  = 8;
  localparam int CPB = 50000000 / 115200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rxd = 1'b1;
  logic        start = 1'b0;
  logic [14:0] addr;
  logic [2:0]  data;
  logic        we, eop, busy, ferr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [14:0] a; logic [2:0] d;} wr_t;
  wr_t sb[$];

  uart_image_loader #(.CLK_FREQ(50000000), .BAUD(115200), .NUM_PIXELS(NP), .ADDR_W(15)) dut (
    .CLOCK_50(clk), .resetn(resetn), .UART_RXD(rxd), .start(start),
    .mem_addr_write(addr), .mem_data_write(data), .memory_write_en(we),
    .endOfUartPackets(eop), .busy(busy), .framing_err(ferr)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input int a, input int d);
    sb.push_back(wr_t'{a: 15'(a), d: 3'(d)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = f[i];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
`ifdef LOADER_PARITY_EN
    send_bits({stop_bit, ^b, b, 1'b0}, 11);
`else
    send_bits({1'b0, stop_bit, b, 1'b0}, 10);
`endif
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic chk_drained(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  // monitor
  logic prev_even = 1'b0, prev_last = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_even = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (prev_even) chk("odd_follows_even", int'(we), 1);
      if (prev_last) chk("eop_after_last", int'(eop), 1);
      if (we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected none at %0t", addr, data, $time);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", int'(addr), int'(e.a));
          chk("wr_data", int'(data), int'(e.d));
        end
        if (addr == 15'(NP - 1)) chk("eop_low_at_last", int'(eop), 0);
      end
      prev_even = we && !addr[0];
      prev_last = we && (addr == 15'(NP - 1));
    end
  end

  initial begin
    repeat (2) tick();
    chk("rst_addr", int'(addr), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_eop", int'(eop), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ferr", int'(ferr), 0);
    resetn = 1'b1;
    tick();

    // single byte 0x2C -> pixels 4,5
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    exp_wr(0, 4); exp_wr(1, 5);
    send_byte(8'h2C, 1'b1);
    chk_drained("single_pending");
    chk("single_busy", int'(busy), 1);
    chk("single_eop", int'(eop), 0);

    // full frame of NP pixels
    do_reset();
    pulse_start();
    exp_wr(0, 7); exp_wr(1, 7); exp_wr(2, 0); exp_wr(3, 0);
    exp_wr(4, 2); exp_wr(5, 2); exp_wr(6, 1); exp_wr(7, 1);
    send_byte(8'h3F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h09, 1'b1);
    chk_drained("frame_pending");
    chk("frame_eop", int'(eop), 1);
    chk("frame_busy", int'(busy), 0);
    pulse_start();
    chk("restart_eop", int'(eop), 0);
    chk("restart_busy", int'(busy), 1);

    // framing error, then a good byte
    do_reset();
    pulse_start();
    send_byte(8'h55, 1'b0);
    chk("ferr_set", int'(ferr), 1);
    exp_wr(0, 7); exp_wr(1, 0);
    send_byte(8'h07, 1'b1);
    chk_drained("ferr_pending");
    chk("ferr_sticky", int'(ferr), 1);

    // bytes before start are dropped; glitch is ignored
    do_reset();
    send_byte(8'h2C, 1'b1);
    chk("idle_busy", int'(busy), 0);
    pulse_start();
    chk("start_clears_ferr", int'(ferr), 0);
    rxd = 1'b0;
    repeat (100) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    chk("glitch_ferr", int'(ferr), 0);
    exp_wr(0, 7); exp_wr(1, 0);
    send_byte(8'h07, 1'b1);
    chk_drained("glitch_pending");

    // reset mid-frame
    do_reset();
    pulse_start();
    exp_wr(0, 7); exp_wr(1, 7); exp_wr(2, 0); exp_wr(3, 0); exp_wr(4, 2); exp_wr(5, 2);
    send_byte(8'h3F, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1);
    chk_drained("mid_pending");
    chk("mid_busy_before", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_addr", int'(addr), 0);
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_eop", int'(eop), 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    pulse_start();
    exp_wr(0, 1); exp_wr(1, 1);
    send_byte(8'h09, 1'b1);
    chk_drained("mid_resume_pending");

`ifdef LOADER_PARITY_EN
    // odd parity on 0x03 -> rejected
    do_reset();
    pulse_start();
    send_bits({1'b1, 1'b1, 8'h03, 1'b0}, 11);
    chk("parity_ferr", int'(ferr), 1);
    chk_drained("parity_pending");
`endif

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
